// File: rtl/mult_control.sv
// Sequencing FSM for the shift-add signed multiplier: clear, WIDTH add/sub decisions, WIDTH shifts, hold.
// Optional MULT_SKIP_ZERO_ADD_EN: an ADD cycle with M=0 shifts directly instead of idling.
module mult_control #(
    parameter int WIDTH = 8
) (
    input  logic Clk,
    input  logic Reset,
    input  logic Run,
    input  logic ClearA_LoadB,
    input  logic M,
    output logic Clr_Ld,
    output logic ClearXA,
    output logic Add,
    output logic Sub,
    output logic Shift,
    output logic Busy,
    output logic Done
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLR   = 3'd1,
        S_ADD   = 3'd2,
        S_SHIFT = 3'd3,
        S_HOLD  = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          last_iter;

    assign last_iter = (cnt_q == CW'(WIDTH - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE:  if (Run) state_d = S_CLR;
            S_CLR: begin
                cnt_d   = '0;
                state_d = S_ADD;
            end
            S_ADD: begin
`ifdef MULT_SKIP_ZERO_ADD_EN
                // With nothing to add, this cycle doubles as the shift cycle
                if (!M) begin
                    if (last_iter) state_d = S_HOLD;
                    else           cnt_d   = cnt_q + 1'b1;
                end else begin
                    state_d = S_SHIFT;
                end
`else
                state_d = S_SHIFT;
`endif
            end
            S_SHIFT: begin
                if (last_iter) begin
                    state_d = S_HOLD;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = S_ADD;
                end
            end
            S_HOLD:  if (!Run) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        Clr_Ld  = 1'b0;
        ClearXA = 1'b0;
        Add     = 1'b0;
        Sub     = 1'b0;
        Shift   = 1'b0;
        Busy    = 1'b0;
        Done    = 1'b0;
        case (state_q)
            S_IDLE:  Clr_Ld = ClearA_LoadB;
            S_CLR: begin
                ClearXA = 1'b1;
                Busy    = 1'b1;
            end
            S_ADD: begin
                Busy = 1'b1;
                // The final partial product carries the multiplier sign weight
                if (M) begin
                    if (last_iter) Sub = 1'b1;
                    else           Add = 1'b1;
                end
`ifdef MULT_SKIP_ZERO_ADD_EN
                else begin
                    Shift = 1'b1;
                end
`endif
            end
            S_SHIFT: begin
                Shift = 1'b1;
                Busy  = 1'b1;
            end
            S_HOLD:  Done = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_mult_control.sv
// Scoreboard bench for mult_control: stimulus queues per-cycle expected controls, a negedge monitor compares.
// Expected vectors follow the documented cycle numbering (MULT_SKIP_ZERO_ADD_EN selects the short schedule).
module tb_mult_control;
    logic Clk = 1'b0;
    logic Reset = 1'b1;
    logic Run = 1'b0;
    logic ClearA_LoadB = 1'b0;
    logic M = 1'b0;
    logic Clr_Ld, ClearXA, Add, Sub, Shift, Busy, Done;

    mult_control #(.WIDTH(8)) dut (
        .Clk(Clk), .Reset(Reset), .Run(Run), .ClearA_LoadB(ClearA_LoadB), .M(M),
        .Clr_Ld(Clr_Ld), .ClearXA(ClearXA), .Add(Add), .Sub(Sub),
        .Shift(Shift), .Busy(Busy), .Done(Done)
    );

    always #5 Clk = ~Clk;

    // Bit order: {Clr_Ld, ClearXA, Add, Sub, Shift, Busy, Done}
    localparam logic [6:0] E_IDLE = 7'b000_0000;
    localparam logic [6:0] E_CL   = 7'b100_0000;
    localparam logic [6:0] E_CLR  = 7'b010_0010;
    localparam logic [6:0] E_ADD  = 7'b001_0010;
    localparam logic [6:0] E_SUB  = 7'b000_1010;
    localparam logic [6:0] E_SH   = 7'b000_0110;
    localparam logic [6:0] E_NOP  = 7'b000_0010;
    localparam logic [6:0] E_DONE = 7'b000_0001;

    typedef struct {
        logic [6:0] exp;
        string      nm;
    } exp_t;

    exp_t       exp_q[$];
    int         n_checks = 0;
    int         n_fail = 0;
    logic       shift_seen = 1'b0;
    logic [7:0] b_model = 8'h00;

    // Monitor: one popped expectation per cycle, sampled mid-cycle
    always @(negedge Clk) begin
        logic [6:0] act;
        exp_t       e;
        act = {Clr_Ld, ClearXA, Add, Sub, Shift, Busy, Done};
        shift_seen <= Shift;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (act !== e.exp) begin
                n_fail++;
                $display("FAIL %s: got %b required %b", e.nm, act, e.exp);
            end else begin
                $display("ok   %s: %b", e.nm, act);
            end
        end
    end

    // Drives one cycle of inputs and queues the controls expected in that cycle
    task automatic step(input logic run, input logic clab, input logic rst,
                        input logic [6:0] exp, input string nm);
        exp_t e;
        @(posedge Clk);
        #1;
        if (shift_seen) b_model = b_model >> 1;
        Reset        = rst;
        Run          = run;
        ClearA_LoadB = clab;
        M            = b_model[0];
        e.exp = exp;
        e.nm  = nm;
        exp_q.push_back(e);
    endtask

    function automatic int done_cycle(input bit is_ff);
`ifdef MULT_SKIP_ZERO_ADD_EN
        if (!is_ff) return 12;
`endif
        return 18;
    endfunction

    // Hand-derived schedules for B=0x03 and B=0xFF, cycle 1 being CLR
    function automatic logic [6:0] exp_op(input bit is_ff, input int c);
        if (c == 1) return E_CLR;
`ifdef MULT_SKIP_ZERO_ADD_EN
        if (!is_ff) begin
            if (c == 2 || c == 4) return E_ADD;
            if (c >= 3 && c <= 11) return E_SH;
            return E_DONE;
        end
`endif
        if (c >= 18) return E_DONE;
        if (c % 2 == 1) return E_SH;
        if (is_ff) return (c == 16) ? E_SUB : E_ADD;
        return (c <= 4) ? E_ADD : E_NOP;
    endfunction

    task automatic do_op(input logic [7:0] b, input bit is_ff, input bit run_pulse,
                         input bit clab_busy, input int hold_extra, input string tag);
        int dc;
        dc = done_cycle(is_ff);
        b_model = b;
        step(1'b1, 1'b0, 1'b0, E_IDLE, $sformatf("%s c0 start", tag));
        for (int c = 1; c < dc; c++)
            step(!run_pulse, clab_busy, 1'b0, exp_op(is_ff, c), $sformatf("%s c%0d", tag, c));
        if (!run_pulse)
            for (int h = 0; h <= hold_extra; h++)
                step(1'b1, 1'b0, 1'b0, E_DONE, $sformatf("%s hold run=1 #%0d", tag, h));
        step(1'b0, 1'b0, 1'b0, E_DONE, $sformatf("%s hold run=0", tag));
        step(1'b0, 1'b0, 1'b0, E_IDLE, $sformatf("%s back idle", tag));
    endtask

    initial begin
        step(1'b0, 1'b0, 1'b1, E_IDLE, "reset held");
        step(1'b0, 1'b0, 1'b0, E_IDLE, "idle after reset");
        step(1'b0, 1'b1, 1'b0, E_CL, "idle clr_ld");
        step(1'b0, 1'b0, 1'b0, E_IDLE, "idle clr_ld released");

        do_op(8'h03, 1'b0, 1'b0, 1'b0, 2, "b03");
        do_op(8'hFF, 1'b1, 1'b1, 1'b1, 0, "bff pulse clab");
        do_op(8'hFF, 1'b1, 1'b0, 1'b0, 0, "bff held");

        // Asynchronous reset while in SHIFT with cnt=3 (cycle 9)
        b_model = 8'hFF;
        step(1'b1, 1'b0, 1'b0, E_IDLE, "rst c0 start");
        for (int c = 1; c <= 8; c++)
            step(1'b1, 1'b0, 1'b0, exp_op(1'b1, c), $sformatf("rst c%0d", c));
        step(1'b1, 1'b0, 1'b1, E_IDLE, "reset mid shift");
        step(1'b0, 1'b1, 1'b0, E_CL, "after reset clr_ld");
        do_op(8'hFF, 1'b1, 1'b1, 1'b0, 0, "restart");

        @(negedge Clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard drain: got %0d pending required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
